// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// reset defaults and the buffered fetch entry layout.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] address;
        logic [31:0] pc_plus_4;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{inst: NOP_INST, address: 32'h0, pc_plus_4: 32'h0};

    // Sequential successor, wrapping naturally at 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Output buffer feeding IF/ID plus a one-entry skid that catches a word
// returned while the downstream stage is stalled.
module fetch_buffer
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  fetch_entry_t load_entry,
    input  logic         flush,
    input  logic         if_id_write,
    output fetch_entry_t out_entry,
    output logic         inst_valid,
    output logic         consume,
    output logic         load_to_skid
);

    fetch_entry_t buf_q;
    fetch_entry_t skid_q;
    logic         valid_q;
    logic         skid_valid_q;

    assign consume      = valid_q && if_id_write;
    assign load_to_skid = load && valid_q && !if_id_write;

    // Flush beats everything; a waiting skid entry refills the buffer
    // before any new word can be accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q        <= EMPTY_ENTRY;
            skid_q       <= EMPTY_ENTRY;
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            if (consume) begin
                buf_q        <= skid_q;
                skid_valid_q <= 1'b0;
            end
        end else if (load) begin
            if (load_to_skid) begin
                skid_q       <= load_entry;
                skid_valid_q <= 1'b1;
            end else begin
                buf_q   <= load_entry;
                valid_q <= 1'b1;
            end
        end else if (consume) begin
            valid_q <= 1'b0;
        end
    end

    assign out_entry  = buf_q;
    assign inst_valid = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and drops fetches made stale by a redirect.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_id_write,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] inst_if,
    output logic [31:0] address_if,
    output logic [31:0] pc_plus_4_if,
    output logic        inst_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pending_q, pending_d;

    logic         buf_load;
    logic         buf_flush;
    fetch_entry_t load_entry;
    fetch_entry_t out_entry;
    logic         consume;
    logic         load_to_skid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            pending_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

    // The PC only moves on an ack or when no request is outstanding, so the
    // address presented to memory stays stable for the whole handshake.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (im_ack) begin
                        pc_d = redirect_target;
                    end else begin
                        pending_d = redirect_target;
                        state_d   = DRAIN;
                    end
                end else if (im_ack) begin
                    pc_d = next_pc(pc_q);
                    if (load_to_skid) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = FETCH;
                end else if (consume) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pending_d = redirect_target;
                    if (im_ack) begin
                        pc_d    = redirect_target;
                        state_d = FETCH;
                    end
                end else if (im_ack) begin
                    pc_d    = pending_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Only a FETCH-state ack carries a live word; DRAIN acks are discarded.
    always_comb begin
        im_req     = rst_n && (state_q != STALL);
        im_addr    = pc_q;
        buf_load   = (state_q == FETCH) && im_ack && !redirect;
        buf_flush  = redirect;
        load_entry = '{inst: im_rdata, address: pc_q, pc_plus_4: next_pc(pc_q)};
    end

    fetch_buffer u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (buf_load),
        .load_entry   (load_entry),
        .flush        (buf_flush),
        .if_id_write  (if_id_write),
        .out_entry    (out_entry),
        .inst_valid   (inst_valid),
        .consume      (consume),
        .load_to_skid (load_to_skid)
    );

    assign inst_if      = out_entry.inst;
    assign address_if   = out_entry.address;
    assign pc_plus_4_if = out_entry.pc_plus_4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a latency-configurable memory model,
// directed scenarios pushing expected fetches, and a consume-side monitor.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_id_write;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] inst_if;
    logic [31:0] address_if;
    logic [31:0] pc_plus_4_if;
    logic        inst_valid;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat = 0;
    int   acks_left = 0;
    int   wait_cnt = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_id_write     (if_id_write),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .im_req          (im_req),
        .im_addr         (im_addr),
        .im_ack          (im_ack),
        .im_rdata        (im_rdata),
        .inst_if         (inst_if),
        .address_if      (address_if),
        .pc_plus_4_if    (pc_plus_4_if),
        .inst_valid      (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    // Memory answers after lat idle request cycles, for at most acks_left requests.
    initial begin
        im_ack   = 1'b0;
        im_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (!im_req || acks_left == 0) begin
                im_ack   = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= lat) begin
                im_ack    = 1'b1;
                im_rdata  = mem_word(im_addr);
                wait_cnt  = 0;
                acks_left = acks_left - 1;
            end else begin
                im_ack   = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end
    end

    // Every instruction accepted downstream must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && inst_valid && if_id_write && !redirect) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL consume_unexpected: got addr=%h inst=%h, required nothing", address_if, inst_if);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (address_if !== e.addr || inst_if !== e.inst || pc_plus_4_if !== e.pc4) begin
                        errors++;
                        $display("[TB] FAIL consume: got addr=%h inst=%h pc4=%h, required addr=%h inst=%h pc4=%h",
                                 address_if, inst_if, pc_plus_4_if, e.addr, e.inst, e.pc4);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic applyStimulus(input logic rst_val, input logic write_val,
                                 input logic redir_val, input logic [31:0] target_val);
        rst_n           = rst_val;
        if_id_write     = write_val;
        redirect        = redir_val;
        redirect_target = target_val;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: a, inst: mem_word(a), pc4: a + 32'd4});
            a = a + 32'd4;
        end
    endtask

    task automatic apply_reset();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        acks_left = 0;
        repeat (2) tick();
        settle();
        checkOutput("rst_im_req", im_req, 0);
        checkOutput("rst_inst_valid", inst_valid, 0);
        checkOutput("rst_inst_if", inst_if, 0);
        checkOutput("rst_address_if", address_if, 0);
        checkOutput("rst_pc_plus_4_if", pc_plus_4_if, 0);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            tick();
            settle();
            k++;
        end
        checkOutput(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Zero-wait streaming from reset
        apply_reset();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        lat = 0; acks_left = 4; expect_seq(32'h0, 4);
        settle();
        checkOutput("t1_im_req", im_req, 1);
        checkOutput("t1_im_addr", im_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            checkOutput("t1_valid", inst_valid, 1);
            checkOutput("t1_address_if", address_if, 32'(4 * i));
            checkOutput("t1_pc_plus_4", pc_plus_4_if, 32'(4 * i + 4));
        end
        wait_drain("t1_drain", 20);

        // Three-cycle memory
        apply_reset();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        lat = 2; acks_left = 3; expect_seq(32'h0, 3);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) tick();
            settle();
            checkOutput("t2_valid", inst_valid, 32'((i % 3 == 0) && (i != 0)));
            checkOutput("t2_im_addr", im_addr, 32'(4 * (i / 3)));
            checkOutput("t2_im_req", im_req, 1);
        end
        wait_drain("t2_drain", 20);

        // Downstream stall fills the skid
        apply_reset();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        lat = 0; acks_left = 6; expect_seq(32'h0, 6);
        tick(); tick();
        tick(); if_id_write = 1'b0; settle();
        checkOutput("t3_hold_addr", address_if, 32'h8);
        tick(); settle();
        checkOutput("t3_stall_req", im_req, 0);
        checkOutput("t3_stall_addr", address_if, 32'h8);
        checkOutput("t3_stall_pc4", pc_plus_4_if, 32'hC);
        tick(); tick();
        tick(); if_id_write = 1'b1; settle();
        checkOutput("t3_release_req", im_req, 0);
        tick(); settle();
        checkOutput("t3_skid_out", address_if, 32'hC);
        tick(); settle();
        checkOutput("t3_after_skid", address_if, 32'h10);
        wait_drain("t3_drain", 20);

        // Redirect with a request outstanding
        apply_reset();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        lat = 0; acks_left = 2; expect_seq(32'h0, 1);
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
        lat = 2; acks_left = 4; expect_seq(32'h40, 3);
        settle();
        checkOutput("t4_pre_valid", inst_valid, 1);
        checkOutput("t4_pre_addr", address_if, 32'h4);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40);
        settle();
        checkOutput("t4_flush_valid", inst_valid, 0);
        checkOutput("t4_drain_req", im_req, 1);
        checkOutput("t4_drain_addr", im_addr, 32'h8);
        tick(); settle();
        checkOutput("t4_stale_addr", im_addr, 32'h8);
        tick(); settle();
        checkOutput("t4_target_addr", im_addr, 32'h40);
        checkOutput("t4_target_valid", inst_valid, 0);
        tick(); tick();
        tick(); settle();
        checkOutput("t4_first_valid", inst_valid, 1);
        checkOutput("t4_first_addr", address_if, 32'h40);
        wait_drain("t4_drain", 30);

        // Redirect colliding with ack and consume; later DRAIN target wins
        apply_reset();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        lat = 0; acks_left = 3; expect_seq(32'h0, 1);
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
        settle();
        checkOutput("t5_pre_addr", address_if, 32'h4);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h80);
        settle();
        checkOutput("t5_flush_valid", inst_valid, 0);
        checkOutput("t5_target_addr", im_addr, 32'h80);
        checkOutput("t5_target_req", im_req, 1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        lat = 2; acks_left = 4; expect_seq(32'h200, 3);
        tick();
        redirect_target = 32'h200;
        settle();
        checkOutput("t5_drain_addr", im_addr, 32'h80);
        checkOutput("t5_drain_valid", inst_valid, 0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("t5_stale_addr", im_addr, 32'h80);
        tick(); settle();
        checkOutput("t5_latest_target", im_addr, 32'h200);
        wait_drain("t5_drain", 40);

        // PC wrap, then reset while draining
        apply_reset();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        lat = 0; acks_left = 3; expect_seq(32'hFFFF_FFFC, 2);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("t6_wrap_req_addr", im_addr, 32'hFFFF_FFFC);
        checkOutput("t6_wrap_flush", inst_valid, 0);
        tick(); settle();
        checkOutput("t6_top_addr", address_if, 32'hFFFF_FFFC);
        checkOutput("t6_top_pc4", pc_plus_4_if, 32'h0);
        checkOutput("t6_wrapped_req", im_addr, 32'h0);
        tick(); settle();
        checkOutput("t6_zero_addr", address_if, 32'h0);
        checkOutput("t6_zero_pc4", pc_plus_4_if, 32'h4);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("t6_drain_req", im_req, 1);
        checkOutput("t6_drain_addr", im_addr, 32'h4);
        wait_drain("t6_pre_reset", 5);
        apply_reset();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        lat = 0; acks_left = 2; expect_seq(32'h0, 2);
        settle();
        checkOutput("t6_reset_addr", im_addr, 32'h0);
        checkOutput("t6_reset_req", im_req, 1);
        wait_drain("t6_drain", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage placed directly upstream of the IF/ID pipeline register. It owns the PC and issues requests to a variable-latency instruction memory using a req/ack handshake. It buffers the returned word with its address and PC+4, and presents them to IF/ID. It honours the downstream stall (if_id_write) and redirects from branch, jump and jr resolution, discarding any in-flight fetch that a redirect makes stale.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and first address fetched.

Ports:
clk  in  1  rising-edge clock for all state
rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
if_id_write  in  1  downstream accepts the presented instruction this cycle
redirect  in  1  control-flow change; overrides sequential fetch
redirect_target  in  32  new PC when redirect=1
im_req  out  1  instruction-memory request
im_addr  out  32  request address; equals the internal PC
im_ack  in  1  memory returns im_rdata this cycle for the outstanding request
im_rdata  in  32  instruction word
inst_if  out  32  buffered instruction to IF/ID
address_if  out  32  address of inst_if
pc_plus_4_if  out  32  address_if + 4, modulo 2^32
inst_valid  out  1  inst_if/address_if/pc_plus_4_if are meaningful

Behaviour:
- Reset (rst_n=0 at an edge) sets the following:
  - pc=RESET_PC, state=FETCH, inst_valid=0, skid_valid=0.
  - inst_if=0, address_if=0, pc_plus_4_if=0.
  - im_req=0 while rst_n=0.
- Reset mid-DRAIN or mid-request abandons the request. Memory tolerates im_req dropping under reset.
- States:
  - FETCH: im_req=1.
  - STALL: im_req=0; the skid is full.
  - DRAIN: im_req=1; a stale request is awaiting its ack.
- im_addr=pc whenever im_req=1. Address and req stay stable until ack (memory protocol).
- Output buffer holds inst/address/pc+4/inst_valid. The buffer is consumed on an edge with inst_valid && if_id_write.
- Skid register has the same fields plus skid_valid.
- FETCH, on im_ack with no redirect:
  - If the buffer is empty or consumed this cycle, load the buffer with {im_rdata, pc, pc+4} and set inst_valid=1.
  - Otherwise load the skid and go to STALL.
  - In both cases pc<=pc+4, with 32-bit wrap (FFFF_FFFC -> 0000_0000).
- FETCH, no ack, buffer consumed: inst_valid<=0, unless the skid refills it.
- STALL:
  - When the buffer is consumed, the buffer takes the skid contents and skid_valid<=0.
  - Next state FETCH (pc is already advanced).
- DRAIN, on im_ack: discard im_rdata, pc<=pending_target, go to FETCH.
- Redirect has highest priority at any edge it is seen:
  - inst_valid<=0 and skid_valid<=0. The buffer is flushed even if if_id_write=1 in the same cycle, so no consume is counted.
  - FETCH with im_ack the same cycle: the response is discarded, pc<=redirect_target, stay in FETCH.
  - FETCH without im_ack: pending_target<=redirect_target, go to DRAIN.
  - STALL: pc<=redirect_target, go to FETCH.
  - DRAIN: pending_target<=redirect_target (latest wins). If im_ack is also set, pc<=redirect_target and go to FETCH.
- Latency: the instruction is visible on the outputs at the edge where im_ack is sampled. With zero-wait memory (im_ack=1 every requested cycle) and if_id_write=1, throughput is one instruction per cycle.
- Redirect penalty: the first redirected request issues in the cycle after the redirect edge. In DRAIN it issues only after the stale ack.
- No instruction is duplicated or dropped across stalls. Outputs hold stable while inst_valid=1 and if_id_write=0.
- redirect_target alignment is unchecked; low bits pass through.

Decomposition:
- Shared package mips_pkg holds:
  - the fetch state encoding (FETCH, STALL, DRAIN);
  - RESET_PC default;
  - NOP_INST = 32'h0000_0000.
- One sub-module, fetch_buffer, holds the output buffer and skid (load, consume, flush). The FSM and PC remain in the top module.

Test Plan:
1. Reset, then zero-wait memory with if_id_write=1: address_if runs 0,4,8,C on consecutive cycles; pc_plus_4_if = address_if+4; inst_if matches memory words.
2. Ack 3 cycles after each req: im_req is held with im_addr=0 for 3 cycles; inst_valid rises once per 3-cycle fetch; no duplicates.
3. Zero-wait memory, if_id_write=0 for 4 cycles from address 8:
   - buffer holds 8, skid takes C, im_req=0;
   - after release, outputs are 8 then C then 10.
4. Redirect to 0x40 with a request outstanding and ack 2 cycles later:
   - inst_valid=0 next edge;
   - the stale word is discarded;
   - the next im_addr is 0x40 and the first valid output has address_if=0x40.
5. Redirect with im_ack and if_id_write in the same cycle: the word is dropped, outputs are flushed, and the next fetch is at the target. A second redirect during DRAIN makes the later target win.
6. Set pc via redirect to 0xFFFF_FFFC: the next fetch is at 0x0000_0000; pc_plus_4_if is 0x0000_0000 for that instruction. Asserting rst_n=0 mid-DRAIN returns the unit to address RESET_PC cleanly.
